// File: rtl/pre_buffer_if.sv
// Handshake and data bundle between the spike generator / STDP controller and pre_buffer.
interface pre_buffer_if;
    logic         i_init;
    logic         i_b_run;
    logic         i_valid;
    logic [3:0]   i_spike;
    logic         i_stdp_run;
    logic [23:0]  o_spike_bundle;
    logic [383:0] o_trace;
    logic         o_valid;
    logic         o_syn_run;
    logic         o_done;

    modport slave (
        input  i_init, i_b_run, i_valid, i_spike, i_stdp_run,
        output o_spike_bundle, o_trace, o_valid, o_syn_run, o_done
    );

    modport master (
        output i_init, i_b_run, i_valid, i_spike, i_stdp_run,
        input  o_spike_bundle, o_trace, o_valid, o_syn_run, o_done
    );
endinterface

// File: rtl/pre_buffer.sv
// 24x24 spike/trace frame buffer: clears on init, accumulates decaying traces per
// received frame, and streams the image out row by row for the STDP stage.
module pre_buffer (
    input  logic        clk,
    input  logic        reset,
    pre_buffer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, INIT, RECV, READ} state_t;

    state_t       state, next;
    logic [7:0]   beat;
    logic [4:0]   row;
    logic [2:0]   grp;
    logic         fin;
    logic         clr_row, wr_beat, ld_row, start_read, last;

    logic [23:0]  spk [24];
    logic [15:0]  trc [24][24];

    // Decay by a quarter, add the spike increment, saturate at full scale.
    function automatic logic [15:0] decay(input logic [15:0] x, input logic s);
        logic [16:0] sum;
        sum = {1'b0, x} - {3'b000, x[15:2]} + (s ? 17'h04000 : 17'h00000);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE: begin
                if (bus.i_b_run)         next = RECV;
                else if (bus.i_init)     next = INIT;
                else if (bus.i_stdp_run) next = READ;
            end
            INIT:    if (row == 5'd23) next = IDLE;
            RECV:    if (bus.i_valid && beat == 8'd143) next = IDLE;
            READ:    if (row == 5'd23) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        clr_row    = 1'b0;
        wr_beat    = 1'b0;
        ld_row     = 1'b0;
        start_read = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: start_read = !bus.i_b_run && !bus.i_init && bus.i_stdp_run;
            INIT: begin
                clr_row = 1'b1;
                last    = (row == 5'd23);
            end
            RECV: begin
                wr_beat = bus.i_valid;
                last    = bus.i_valid && (beat == 8'd143);
            end
            READ: begin
                ld_row = 1'b1;
                last   = (row == 5'd23);
            end
            default: ;
        endcase
    end

    // In RECV the row/grp pair tracks beat/6 and beat%6 so no divider is needed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat <= '0;
            row  <= '0;
            grp  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    beat <= '0;
                    row  <= '0;
                    grp  <= '0;
                end
                INIT, READ: row <= (row == 5'd23) ? 5'd0 : row + 5'd1;
                RECV: begin
                    if (bus.i_valid) begin
                        beat <= beat + 8'd1;
                        if (grp == 3'd5) begin
                            grp <= '0;
                            row <= row + 5'd1;
                        end else begin
                            grp <= grp + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < 24; r++) begin
                spk[r] <= '0;
                for (int unsigned c = 0; c < 24; c++) trc[r][c] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < 24; c++) begin
                if (clr_row) begin
                    spk[row][c] <= 1'b0;
                    trc[row][c] <= '0;
                end else if (wr_beat && c[4:2] == grp) begin
                    spk[row][c] <= bus.i_spike[c[1:0]];
                    trc[row][c] <= decay(trc[row][c], bus.i_spike[c[1:0]]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.o_spike_bundle <= '0;
            bus.o_trace        <= '0;
            bus.o_valid        <= 1'b0;
            bus.o_syn_run      <= 1'b0;
            bus.o_done         <= 1'b0;
            fin                <= 1'b0;
        end else begin
            if (ld_row) begin
                bus.o_spike_bundle <= spk[row];
                for (int unsigned c = 0; c < 24; c++) bus.o_trace[16*c +: 16] <= trc[row][c];
                bus.o_valid <= 1'b1;
            end else begin
                bus.o_spike_bundle <= '0;
                bus.o_trace        <= '0;
                bus.o_valid        <= 1'b0;
            end
            bus.o_syn_run <= start_read;
            fin           <= last;
            bus.o_done    <= fin;
        end
    end
endmodule

// File: tb/tb_pre_buffer.sv
// Self-checking bench for pre_buffer: fixed frame vectors, ordering, random frames
// against a pixel-level trace model, saturation and reset abort.
module tb_pre_buffer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pre_buffer_if bus ();
    pre_buffer dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad   = 0;

    bit           m_spk [576];
    int           m_trc [576];
    logic [3:0]   fr    [144];
    logic [23:0]  got_b [24];
    logic [383:0] got_t [24];

    typedef struct {
        bit          do_init;
        bit          do_frame;
        logic [3:0]  nib;
        logic [23:0] eb;
        logic [15:0] et;
    } vec_t;
    vec_t tbl [4];

    task automatic check(input string name, input logic [383:0] got, input logic [383:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int p = 0; p < 576; p++) begin
            m_spk[p] = 1'b0;
            m_trc[p] = 0;
        end
    endfunction

    function automatic void model_beat(input int b, input logic [3:0] nib);
        for (int k = 0; k < 4; k++) begin
            int p = 4 * b + k;
            m_spk[p] = nib[k];
            m_trc[p] = m_trc[p] - m_trc[p] / 4 + (nib[k] ? 16384 : 0);
            if (m_trc[p] > 65535) m_trc[p] = 65535;
        end
    endfunction

    task automatic do_init();
        int n = 0;
        @(negedge clk); bus.i_init = 1'b1;
        @(negedge clk); bus.i_init = 1'b0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (bus.o_done) break;
        end
        check("init_latency", n, 25);
        model_clear();
    endtask

    task automatic run_frame(input bit gaps);
        @(negedge clk); bus.i_b_run = 1'b1;
        @(negedge clk); bus.i_b_run = 1'b0;
        for (int b = 0; b < 144; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                int n = $urandom_range(1, 3);
                for (int g = 0; g < n; g++) begin
                    bus.i_valid = 1'b0;
                    bus.i_spike = 4'($urandom);
                    case ($urandom_range(0, 2))
                        0:       bus.i_stdp_run = 1'b1;
                        1:       bus.i_init     = 1'b1;
                        default: bus.i_b_run    = 1'b1;
                    endcase
                    @(negedge clk);
                    bus.i_stdp_run = 1'b0;
                    bus.i_init     = 1'b0;
                    bus.i_b_run    = 1'b0;
                end
            end
            bus.i_valid = 1'b1;
            bus.i_spike = fr[b];
            @(negedge clk);
            model_beat(b, fr[b]);
        end
        bus.i_valid = 1'b0;
        bus.i_spike = '0;
        check("frame_done_early", bus.o_done, 0);
        @(negedge clk);
        check("frame_done", bus.o_done, 1);
    endtask

    // abort_row < 0 runs a full readout; otherwise reset is raised after that row.
    task automatic readout(input int abort_row);
        int dn = 0;
        @(negedge clk); bus.i_stdp_run = 1'b1;
        @(negedge clk); bus.i_stdp_run = 1'b0;
        check("syn_run_start", bus.o_syn_run, 1);
        check("valid_before_rows", bus.o_valid, 0);
        for (int r = 0; r < 24; r++) begin
            @(negedge clk);
            check($sformatf("row_valid_r%0d", r), bus.o_valid, 1);
            check($sformatf("syn_run_once_r%0d", r), bus.o_syn_run, 0);
            got_b[r] = bus.o_spike_bundle;
            got_t[r] = bus.o_trace;
            if (r == abort_row) begin
                reset = 1'b1;
                #1;
                check("abort_valid", bus.o_valid, 0);
                check("abort_bundle", bus.o_spike_bundle, 0);
                check("abort_trace", bus.o_trace, 0);
                check("abort_done", bus.o_done, 0);
                repeat (2) @(negedge clk);
                reset = 1'b0;
                model_clear();
                repeat (30) begin
                    @(negedge clk);
                    if (bus.o_done || bus.o_valid) dn++;
                end
                check("abort_no_done", dn, 0);
                return;
            end
        end
        @(negedge clk);
        check("read_end_valid", bus.o_valid, 0);
        check("read_done", bus.o_done, 1);
        check("idle_bundle_zero", bus.o_spike_bundle, 0);
        check("idle_trace_zero", bus.o_trace, 0);
        @(negedge clk);
        check("read_done_pulse", bus.o_done, 0);
    endtask

    task automatic check_model(input string tag);
        for (int r = 0; r < 24; r++) begin
            logic [23:0]  eb;
            logic [383:0] et;
            for (int c = 0; c < 24; c++) begin
                eb[c]          = m_spk[r * 24 + c];
                et[16*c +: 16] = 16'(m_trc[r * 24 + c]);
            end
            check($sformatf("%s_bundle_r%0d", tag, r), got_b[r], eb);
            check($sformatf("%s_trace_r%0d", tag, r), got_t[r], et);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_init     = 1'b0;
        bus.i_b_run    = 1'b0;
        bus.i_valid    = 1'b0;
        bus.i_spike    = '0;
        bus.i_stdp_run = 1'b0;
        reset          = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", bus.o_valid, 0);
        check("rst_done", bus.o_done, 0);
        check("rst_syn_run", bus.o_syn_run, 0);
        check("rst_bundle", bus.o_spike_bundle, 0);
        check("rst_trace", bus.o_trace, 0);
        reset = 1'b0;
        model_clear();

        tbl[0] = '{do_init: 1'b1, do_frame: 1'b0, nib: 4'h0, eb: 24'h000000, et: 16'h0000};
        tbl[1] = '{do_init: 1'b0, do_frame: 1'b1, nib: 4'hF, eb: 24'hFFFFFF, et: 16'h4000};
        tbl[2] = '{do_init: 1'b0, do_frame: 1'b1, nib: 4'hF, eb: 24'hFFFFFF, et: 16'h7000};
        tbl[3] = '{do_init: 1'b0, do_frame: 1'b1, nib: 4'h0, eb: 24'h000000, et: 16'h5400};
        for (int i = 0; i < 4; i++) begin
            if (tbl[i].do_init) do_init();
            if (tbl[i].do_frame) begin
                for (int b = 0; b < 144; b++) fr[b] = tbl[i].nib;
                run_frame(i == 2);
            end
            readout(-1);
            for (int r = 0; r < 24; r++) begin
                check($sformatf("vec%0d_bundle_r%0d", i, r), got_b[r], tbl[i].eb);
                check($sformatf("vec%0d_trace_r%0d", i, r), got_t[r], {24{tbl[i].et}});
            end
        end

        do_init();
        for (int b = 0; b < 144; b++) fr[b] = 4'h0;
        fr[0]   = 4'b0001;
        fr[143] = 4'b1000;
        run_frame(1'b1);
        readout(-1);
        check("order_row0_bundle", got_b[0], 24'h000001);
        check("order_row23_bundle", got_b[23], 24'h800000);
        check("order_row0_trace", got_t[0], {368'h0, 16'h4000});
        check("order_row23_trace", got_t[23], {16'h4000, 368'h0});
        check_model("order");

        repeat (3) begin
            for (int b = 0; b < 144; b++) fr[b] = 4'($urandom);
            run_frame(1'b1);
            readout(-1);
            check_model("rand");
        end

        do_init();
        for (int b = 0; b < 144; b++) fr[b] = 4'hF;
        repeat (42) run_frame(1'b0);
        readout(-1);
        check("sat_trace_r5", got_t[5], {24{16'hFFFF}});
        check_model("sat");

        readout(10);
        readout(-1);
        check_model("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
